// File: rtl/btn_pkg.sv
// Shared definitions for the push-button controller array:
// hold-FSM state encodings and a counter width helper.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } hold_st_t;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchroniser, tick-based debounce,
// registered edge pulses and the long-press / auto-repeat FSM.
module button_channel
    import btn_pkg::*;
#(
    parameter int DB_SAMPLES   = 4,
    parameter int LONG_TICKS   = 50,
    parameter int REPEAT_TICKS = 10,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic reset_p,
    input  logic tick,
    input  logic btn,
    output logic btn_level,
    output logic btn_pe,
    output logic btn_ne,
    output logic btn_long,
    output logic btn_rpt
);

    localparam int DW   = cnt_w(DB_SAMPLES);
    localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ?
                          LONG_TICKS : REPEAT_TICKS;
    localparam int HW   = cnt_w(HMAX);

    localparam logic [DW-1:0] DB_LIM   = DW'(DB_SAMPLES);
    localparam logic [HW-1:0] LONG_LIM = HW'(LONG_TICKS);
    localparam logic [HW-1:0] RPT_LIM  = HW'(REPEAT_TICKS);

    logic          r_s1;
    logic          r_s2;
    logic [DW-1:0] r_db_cnt;
    logic          r_level;
    logic          r_level_d;
    logic          r_pe;
    logic          r_ne;
    hold_st_t      r_state;
    logic [HW-1:0] r_hold_cnt;
    logic          r_long;
    logic          r_rpt;

    logic          w_sync;
    logic          w_level_nx;
    logic [DW-1:0] w_db_nx;
    hold_st_t      w_state_nx;
    logic [HW-1:0] w_hold_nx;
    logic [HW-1:0] w_hold_inc;
    logic          w_long;
    logic          w_rpt;

    assign w_sync     = r_s2 ^ ACTIVE_LOW;
    assign w_hold_inc = (r_hold_cnt == '1) ? r_hold_cnt
                                           : r_hold_cnt + 1'b1;

    always_comb begin
        w_level_nx = r_level;
        w_db_nx    = r_db_cnt;
        if (tick) begin
            if (w_sync == r_level) begin
                w_db_nx = '0;
            end else if (r_db_cnt >= DB_LIM - 1'b1) begin
                w_level_nx = ~r_level;
                w_db_nx    = '0;
            end else begin
                w_db_nx = r_db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_s1      <= ACTIVE_LOW;
            r_s2      <= ACTIVE_LOW;
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_pe      <= 1'b0;
            r_ne      <= 1'b0;
        end else begin
            r_s1      <= btn;
            r_s2      <= r_s1;
            r_db_cnt  <= w_db_nx;
            r_level   <= w_level_nx;
            r_level_d <= r_level;
            r_pe      <= r_level & ~r_level_d;
            r_ne      <= ~r_level & r_level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_long     <= 1'b0;
            r_rpt      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_hold_cnt <= w_hold_nx;
            r_long     <= w_long;
            r_rpt      <= w_rpt;
        end
    end

    // The debounced next level gates the FSM so a release on a threshold tick wins.
    always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = r_hold_cnt;
        if (!w_level_nx) begin
            w_state_nx = ST_IDLE;
            w_hold_nx  = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (r_pe) begin
                        w_state_nx = ST_PRESSED;
                        w_hold_nx  = '0;
                    end
                end
                ST_PRESSED: begin
                    if (tick) begin
                        if (w_hold_inc >= LONG_LIM) begin
                            w_state_nx = ST_HELD;
                            w_hold_nx  = '0;
                        end else begin
                            w_hold_nx = w_hold_inc;
                        end
                    end
                end
                ST_HELD: begin
                    if (tick && REPEAT_TICKS != 0) begin
                        if (w_hold_inc >= RPT_LIM) begin
                            w_hold_nx = '0;
                        end else begin
                            w_hold_nx = w_hold_inc;
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_hold_nx  = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_long = 1'b0;
        w_rpt  = 1'b0;
        if (w_level_nx && tick) begin
            if (r_state == ST_PRESSED && w_hold_inc >= LONG_LIM) begin
                w_long = 1'b1;
            end
            if (r_state == ST_HELD && REPEAT_TICKS != 0 &&
                w_hold_inc >= RPT_LIM) begin
                w_rpt = 1'b1;
            end
        end
    end

    assign btn_level = r_level;
    assign btn_pe    = r_pe;
    assign btn_ne    = r_ne;
    assign btn_long  = r_long;
    assign btn_rpt   = r_rpt;

endmodule

// File: rtl/button_cntr_array.sv
// N independent debounced button channels sharing one
// sample-tick divider.
module button_cntr_array
    import btn_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 100000,
    parameter int DB_SAMPLES   = 4,
    parameter int LONG_TICKS   = 50,
    parameter int REPEAT_TICKS = 10,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pe,
    output logic [N_BTN-1:0] btn_ne,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_rpt
);

    localparam int            TW        = cnt_w(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        button_channel #(
            .DB_SAMPLES   (DB_SAMPLES),
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .reset_p   (reset_p),
            .tick      (w_tick),
            .btn       (btn[g]),
            .btn_level (btn_level[g]),
            .btn_pe    (btn_pe[g]),
            .btn_ne    (btn_ne[g]),
            .btn_long  (btn_long[g]),
            .btn_rpt   (btn_rpt[g])
        );
    end

endmodule

// File: tb/tb_button_cntr_array.sv
// Bench for button_cntr_array: an active-high build with repeat and an
// active-low build with repeat disabled, both checked against a tick model.
module tb_button_cntr_array;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int DB = 3;
    localparam int LT = 5;
    localparam int RT = 2;

    logic         clk = 1'b0;
    logic         reset_p;
    logic [N-1:0] btn;
    logic [N-1:0] w_btn_n;
    logic [N-1:0] lv0, pe0, ne0, lg0, rp0;
    logic [N-1:0] lv1, pe1, ne1, lg1, rp1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    assign w_btn_n = ~btn;

    always #5 clk = ~clk;

    button_cntr_array #(
        .N_BTN(N), .TICK_DIV(TD), .DB_SAMPLES(DB),
        .LONG_TICKS(LT), .REPEAT_TICKS(RT), .ACTIVE_LOW(1'b0)
    ) dut0 (
        .clk(clk), .reset_p(reset_p), .btn(btn),
        .btn_level(lv0), .btn_pe(pe0), .btn_ne(ne0),
        .btn_long(lg0), .btn_rpt(rp0)
    );

    button_cntr_array #(
        .N_BTN(N), .TICK_DIV(TD), .DB_SAMPLES(DB),
        .LONG_TICKS(LT), .REPEAT_TICKS(0), .ACTIVE_LOW(1'b1)
    ) dut1 (
        .clk(clk), .reset_p(reset_p), .btn(w_btn_n),
        .btn_level(lv1), .btn_pe(pe1), .btn_ne(ne1),
        .btn_long(lg1), .btn_rpt(rp1)
    );

    // Model: instance 0 is active-high with repeat, instance 1 is
    // active-low (pins = ~btn) with repeat disabled.
    int           cyc;
    logic [N-1:0] m_h1[2], m_h2[2], m_lvl[2], m_lvlp[2];
    logic [N-1:0] m_pe[2], m_ne[2], m_lg[2], m_rp[2], m_arm[2];
    int           m_run[2][N];
    int           m_age[2][N];

    function automatic bit al_of(input int i);
        return (i == 1);
    endfunction

    function automatic int rt_of(input int i);
        return (i == 0) ? RT : 0;
    endfunction

    always @(posedge clk) begin : model
        bit tk, pin, sv, nl, npe, nne, nlg, nrp;
        if (reset_p) begin
            cyc = 0;
            for (int i = 0; i < 2; i++) begin
                m_h1[i] = al_of(i) ? '1 : '0;
                m_h2[i] = m_h1[i];
                m_lvl[i] = '0; m_lvlp[i] = '0;
                m_pe[i] = '0; m_ne[i] = '0;
                m_lg[i] = '0; m_rp[i] = '0;
                m_arm[i] = '0;
                for (int c = 0; c < N; c++) begin
                    m_run[i][c] = 0;
                    m_age[i][c] = 0;
                end
            end
        end else begin
            tk = ((cyc % TD) == TD - 1);
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < N; c++) begin
                    pin = (i == 0) ? btn[c] : ~btn[c];
                    sv  = m_h2[i][c] ^ al_of(i);
                    npe = m_lvl[i][c] && !m_lvlp[i][c];
                    nne = !m_lvl[i][c] && m_lvlp[i][c];
                    nl  = m_lvl[i][c];
                    if (tk) begin
                        if (sv != m_lvl[i][c]) begin
                            m_run[i][c]++;
                            if (m_run[i][c] >= DB) begin
                                nl = !nl;
                                m_run[i][c] = 0;
                            end
                        end else begin
                            m_run[i][c] = 0;
                        end
                    end
                    nlg = 0;
                    nrp = 0;
                    if (!nl) begin
                        m_arm[i][c] = 0;
                        m_age[i][c] = 0;
                    end else if (m_pe[i][c]) begin
                        m_arm[i][c] = 1;
                        m_age[i][c] = 0;
                    end else if (m_arm[i][c] && tk) begin
                        m_age[i][c]++;
                        if (m_age[i][c] == LT) nlg = 1;
                        else if (rt_of(i) != 0 && m_age[i][c] > LT &&
                                 (m_age[i][c] - LT) % rt_of(i) == 0)
                            nrp = 1;
                    end
                    m_h2[i][c]   = m_h1[i][c];
                    m_h1[i][c]   = pin;
                    m_lvlp[i][c] = m_lvl[i][c];
                    m_lvl[i][c]  = nl;
                    m_pe[i][c]   = npe;
                    m_ne[i][c]   = nne;
                    m_lg[i][c]   = nlg;
                    m_rp[i][c]   = nrp;
                end
            end
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("lvl0", lv0, m_lvl[0]);
            chk("pe0",  pe0, m_pe[0]);
            chk("ne0",  ne0, m_ne[0]);
            chk("long0", lg0, m_lg[0]);
            chk("rpt0", rp0, m_rp[0]);
            chk("lvl1", lv1, m_lvl[1]);
            chk("pe1",  pe1, m_pe[1]);
            chk("ne1",  ne1, m_ne[1]);
            chk("long1", lg1, m_lg[1]);
            chk("rpt1", rp1, m_rp[1]);
        end
    end

    int c_pe[N], c_ne[N], c_lg[N], c_rp[N];
    int c1_pe[N], c1_rp[N];

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                c_pe[c]  += int'(pe0[c]);
                c_ne[c]  += int'(ne0[c]);
                c_lg[c]  += int'(lg0[c]);
                c_rp[c]  += int'(rp0[c]);
                c1_pe[c] += int'(pe1[c]);
                c1_rp[c] += int'(rp1[c]);
            end
        end
    endtask

    // sel: 0 = press pulse, 1 = release pulse, 2 = long pulse.
    task automatic wait_ev(input string nm, input int sel, input int ch,
                           output int n);
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 80) begin
            step(1);
            n++;
            case (sel)
                0:       hit = pe0[ch];
                1:       hit = ne0[ch];
                default: hit = lg0[ch];
            endcase
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: no pulse within %0d cycles", nm, n);
        end
    endtask

    task automatic rst_zero(input string nm);
        chk({nm, "_lvl"}, lv0 | lv1, '0);
        chk({nm, "_pls"}, pe0 | ne0 | lg0 | rp0 | pe1 | ne1 | lg1 | rp1, '0);
    endtask

    initial begin
        int n, l0, r0, e0, p0;
        reset_p = 1'b1;
        btn     = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rst_zero("reset");
        reset_p = 1'b0;
        step(8);
        chk("idle_al_lvl", lv1, '0);

        // Clean press and release on channel 0.
        btn[0] = 1'b1;
        wait_ev("s1_pe", 0, 0, n);
        lit("s1_pe_lat", int'(n >= 12 && n <= 15), 1);
        chk("s1_lvl", lv0 & 4'b0001, 4'b0001);
        step(10 * TD);
        btn[0] = 1'b0;
        wait_ev("s1_ne", 1, 0, n);
        lit("s1_ne_lat", int'(n >= 12 && n <= 15), 1);
        lit("s1_pe_cnt", c_pe[0], 1);
        lit("s1_ne_cnt", c_ne[0], 1);
        lit("s1_al_pe_cnt", c1_pe[0], 1);

        // Bounce on channel 1: 2 ticks high, 1 low, then steady.
        btn[1] = 1'b1;
        step(2 * TD);
        btn[1] = 1'b0;
        step(TD);
        btn[1] = 1'b1;
        step(2 * TD);
        lit("s2_early_pe", c_pe[1], 0);
        wait_ev("s2_pe", 0, 1, n);
        step(10 * TD);
        lit("s2_pe_cnt", c_pe[1], 1);
        lit("s2_ne_cnt", c_ne[1], 0);

        // Long hold on channel 2: long at tick 5, repeats at 7, 9, 11.
        btn[2] = 1'b1;
        wait_ev("s3_pe", 0, 2, n);
        l0 = c_lg[2];
        r0 = c_rp[2];
        step(12 * TD);
        lit("s3_long", c_lg[2] - l0, 1);
        lit("s3_rpt", c_rp[2] - r0, 3);
        lit("s3_al_rpt", c1_rp[2], 0);
        btn[2] = 1'b0;
        wait_ev("s3_ne", 1, 2, n);
        step(4 * TD);

        // Short press: release accepted at hold tick 4, then at tick 5.
        for (int k = 0; k < 2; k++) begin
            btn[2] = 1'b1;
            wait_ev("s4_pe", 0, 2, n);
            l0 = c_lg[2];
            r0 = c_rp[2];
            e0 = c_ne[2];
            step(4 + 4 * k);
            btn[2] = 1'b0;
            wait_ev("s4_ne", 1, 2, n);
            lit("s4_long", c_lg[2] - l0, 0);
            lit("s4_rpt", c_rp[2] - r0, 0);
            lit("s4_ne", c_ne[2] - e0, 1);
            step(4 * TD);
        end

        // Reset while channel 3 is held past long.
        btn[3] = 1'b1;
        wait_ev("s5_long", 2, 3, n);
        step(2);
        reset_p = 1'b1;
        step(1);
        rst_zero("s5_rst1");
        step(1);
        rst_zero("s5_rst2");
        reset_p = 1'b0;
        p0 = c_pe[3];
        wait_ev("s5_repe", 0, 3, n);
        lit("s5_repe_lat", int'(n >= 12 && n <= 15), 1);
        lit("s5_repe_cnt", c_pe[3] - p0, 1);

        btn = '0;
        step(20 * TD);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
